// File: rtl/gshare_predictor.sv
// gshare_predictor: global-history branch direction predictor with a direct-mapped
// branch target buffer.
//
// Lookup and prediction are purely combinational from registered state; all updates
// happen on the rising edge of clk and only while rdy is high (reset excepted).
//
// Parameters
//   IDX_W      pattern-table index width (2^IDX_W two-bit counters)
//   HIST_W     global history width, 1..IDX_W
//   BTB_IDX_W  target-buffer index width (2^BTB_IDX_W entries)
//   MODE       1 = gshare (pc XOR history) indexing, 0 = bimodal (pc only)
//
// Ports
//   clk, rst            clock, synchronous active-high reset
//   rdy                 global enable; low freezes all state
//   if_valid            fetch lookup this cycle
//   if_is_branch        fetched instruction is a conditional branch
//   if_pc               fetch PC
//   predict_taken       predicted direction
//   predict_target      predicted target (meaningful when predict_taken)
//   predict_ghr         history snapshot used by this lookup
//   commit_valid        a branch retires this cycle
//   commit_pc           retiring branch PC
//   commit_taken        actual outcome
//   commit_target       actual taken target
//   commit_ghr          snapshot that travelled with the branch
//   commit_mispredict   branch was mispredicted; repair history
module gshare_predictor #(
  parameter int unsigned IDX_W     = 7,
  parameter int unsigned HIST_W    = 7,
  parameter int unsigned BTB_IDX_W = 4,
  parameter int unsigned MODE      = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rdy,
  input  logic              if_valid,
  input  logic              if_is_branch,
  input  logic [31:0]       if_pc,
  output logic              predict_taken,
  output logic [31:0]       predict_target,
  output logic [HIST_W-1:0] predict_ghr,
  input  logic              commit_valid,
  input  logic [31:0]       commit_pc,
  input  logic              commit_taken,
  input  logic [31:0]       commit_target,
  input  logic [HIST_W-1:0] commit_ghr,
  input  logic              commit_mispredict
);

  localparam int unsigned NumCnt = 1 << IDX_W;
  localparam int unsigned NumBtb = 1 << BTB_IDX_W;
  localparam int unsigned TagW   = 30 - BTB_IDX_W;

  logic [1:0]        cnt_q       [NumCnt];
  logic [HIST_W-1:0] ghr_q;
  logic [HIST_W-1:0] ghr_d;
  logic              btb_valid_q [NumBtb];
  logic [TagW-1:0]   btb_tag_q   [NumBtb];
  logic [31:0]       btb_tgt_q   [NumBtb];

  logic [IDX_W-1:0]     fetch_idx;
  logic [IDX_W-1:0]     commit_idx;
  logic [BTB_IDX_W-1:0] fetch_btb;
  logic [BTB_IDX_W-1:0] commit_btb;
  logic                 btb_hit;
  logic [1:0]           cnt_cur;
  logic [1:0]           cnt_upd;

  // PC bits [1:0] never participate: instructions are word aligned.
  logic unused_pc_lsb;
  assign unused_pc_lsb = ^{if_pc[1:0], commit_pc[1:0]};

  // Index generation; history is zero-extended when narrower than the index.
  always_comb begin
    fetch_idx  = if_pc[IDX_W+1:2];
    commit_idx = commit_pc[IDX_W+1:2];
    if (MODE == 1) begin
      fetch_idx  = fetch_idx ^ IDX_W'(ghr_q);
      commit_idx = commit_idx ^ IDX_W'(commit_ghr);
    end
  end

  assign fetch_btb  = if_pc[BTB_IDX_W+1:2];
  assign commit_btb = commit_pc[BTB_IDX_W+1:2];

  // Lookup: zero-latency read of registered state, so a same-cycle commit is
  // only visible from the following cycle.
  always_comb begin
    btb_hit        = btb_valid_q[fetch_btb] && (btb_tag_q[fetch_btb] == if_pc[31:BTB_IDX_W+2]);
    predict_taken  = cnt_q[fetch_idx][1] & btb_hit;
    predict_target = btb_hit ? btb_tgt_q[fetch_btb] : 32'h0;
    predict_ghr    = ghr_q;
  end

  // Saturating two-bit counter update.
  always_comb begin
    cnt_cur = cnt_q[commit_idx];
    cnt_upd = cnt_cur;
    if (commit_taken) begin
      if (cnt_cur != 2'b11) cnt_upd = cnt_cur + 2'b01;
    end else begin
      if (cnt_cur != 2'b00) cnt_upd = cnt_cur - 2'b01;
    end
  end

  // History: misprediction repair beats the speculative shift of a same-cycle lookup.
  // The casts drop the oldest bit, which also covers HIST_W == 1.
  always_comb begin
    ghr_d = ghr_q;
    if (commit_valid && commit_mispredict) begin
      ghr_d = HIST_W'({commit_ghr, commit_taken});
    end else if (if_valid && if_is_branch) begin
      ghr_d = HIST_W'({ghr_q, predict_taken});
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NumCnt; i++) cnt_q[i] <= 2'b01;
      for (int i = 0; i < NumBtb; i++) btb_valid_q[i] <= 1'b0;
      ghr_q <= '0;
    end else if (rdy) begin
      if (commit_valid) begin
        cnt_q[commit_idx] <= cnt_upd;
        if (commit_taken) begin
          btb_valid_q[commit_btb] <= 1'b1;
          btb_tag_q[commit_btb]   <= commit_pc[31:BTB_IDX_W+2];
          btb_tgt_q[commit_btb]   <= commit_target;
        end
      end
      ghr_q <= ghr_d;
    end
  end

endmodule

// File: doc/gshare_predictor.md
GSHARE_PREDICTOR -- requirements
Module: gshare_predictor

Interface
REQ-001 The block SHALL have parameter IDX_W, default 7, meaning pattern-table index width (2^IDX_W two-bit counters).
REQ-002 The block SHALL have parameter HIST_W, default 7, meaning global history width, legal range 1..IDX_W.
REQ-003 The block SHALL have parameter BTB_IDX_W, default 4, meaning target-buffer index width (2^BTB_IDX_W direct-mapped entries).
REQ-004 The block SHALL have parameter MODE, default 1, meaning 1 = gshare indexing, 0 = bimodal indexing (history ignored for indexing, still tracked).
REQ-005 The block SHALL have port clk  input  1  clock, all state updates on rising edge.
REQ-006 The block SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-007 The block SHALL have port rdy  input  1  global enable; low freezes all state except reset.
REQ-008 The block SHALL have port if_valid  input  1  fetch lookup this cycle.
REQ-009 The block SHALL have port if_is_branch  input  1  fetched instruction is a conditional branch.
REQ-010 The block SHALL have port if_pc  input  32  fetch PC.
REQ-011 The block SHALL have port predict_taken  output  1  predicted direction.
REQ-012 The block SHALL have port predict_target  output  32  predicted target, valid only when predict_taken=1.
REQ-013 The block SHALL have port predict_ghr  output  HIST_W  history snapshot used for this lookup, carried with the branch to commit.
REQ-014 The block SHALL have port commit_valid  input  1  one branch retires this cycle.
REQ-015 The block SHALL have port commit_pc  input  32  retiring branch PC.
REQ-016 The block SHALL have port commit_taken  input  1  actual outcome.
REQ-017 The block SHALL have port commit_target  input  32  actual taken target.
REQ-018 The block SHALL have port commit_ghr  input  HIST_W  snapshot returned from predict_ghr.
REQ-019 The block SHALL have port commit_mispredict  input  1  retiring branch was mispredicted (direction or target).

Function
REQ-020 The block SHALL compute the fetch index as if_pc[IDX_W+1:2] XOR zero-extended ghr when MODE=1, and as if_pc[IDX_W+1:2] when MODE=0.
REQ-021 The block SHALL compute the commit index identically, using commit_pc and commit_ghr.
REQ-022 The block SHALL drive predict_taken, predict_target and predict_ghr combinationally from registered state, with zero-cycle lookup latency.
REQ-023 The block SHALL drive predict_ghr equal to the current ghr register.
REQ-024 The block SHALL report a BTB hit when the entry at if_pc[BTB_IDX_W+1:2] is valid and its tag equals if_pc[31:BTB_IDX_W+2].
REQ-025 The block SHALL set predict_taken = counter[idx][1] AND btb_hit, and predict_target = stored target on hit, else 0.
REQ-026 The block SHALL, when rdy and commit_valid, saturate counter[commit index] +1 if commit_taken (max 2'b11) and -1 otherwise (min 2'b00).
REQ-027 The block SHALL, when rdy and commit_valid and commit_taken, write the BTB entry at commit_pc index with valid=1, tag and commit_target, overwriting any prior entry.
REQ-028 The block SHALL leave the BTB unchanged on a not-taken commit.
REQ-029 The block SHALL, when rdy, if_valid, if_is_branch and no commit_mispredict, shift ghr left by one and insert predict_taken at bit 0.
REQ-030 The block SHALL, when rdy, commit_valid and commit_mispredict, load ghr with {commit_ghr[HIST_W-2:0], commit_taken} (commit_taken alone when HIST_W=1), overriding any same-cycle speculative shift.
REQ-031 The block SHALL, on a same-cycle lookup and commit to one counter or BTB entry, return the pre-update value to the lookup; the update is visible the next cycle.
REQ-032 The block SHALL keep all state unchanged while rdy=0, with outputs still tracking if_pc.
REQ-033 The block SHALL ignore commit_mispredict when commit_valid=0.

Reset
REQ-034 The block SHALL, on rst=1 at a rising edge, regardless of rdy, set all counters to 2'b01, ghr to 0 and all BTB valid bits to 0.
REQ-035 The block SHALL give reset priority over every same-cycle commit and lookup update.
REQ-036 The block SHALL drive predict_taken=0, predict_target=0 and predict_ghr=0 after reset until the first taken commit.

Verification
REQ-037 The bench SHALL cover: reset, then lookup pc=0x100 -> predict_taken=0, predict_ghr=0.
REQ-038 The bench SHALL cover: MODE=0, two taken commits pc=0x100 target 0x80 -> counter 01->11; lookup pc=0x100 -> taken=1, target=0x80.
REQ-039 The bench SHALL cover: four not-taken commits on a saturated-taken entry -> counter reaches 00 and stays 00 on the fourth, prediction 0 after the second.
REQ-040 The bench SHALL cover: three branch lookups predicting 1,0,1 from ghr=0 -> ghr=3'b101 in the low bits; then mispredict commit with commit_ghr=0, taken=0 in the same cycle as a branch lookup -> ghr=0.
REQ-041 The bench SHALL cover: BTB aliasing, taken commits pc=0x100 then pc=0x140 (BTB_IDX_W=4) -> lookup 0x100 misses, taken=0.
REQ-042 The bench SHALL cover: rdy=0 with a taken commit -> no state change; rst=1 with rdy=0 -> state reset.
